// File: rtl/iic_arb.sv
// ============================================================================
// Module   : iic_arb
// Brief    : Round-robin two-requester arbiter and sequencer for one IIC byte
//            driver, with done synchronisation, timeout and EEPROM write wait.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module iic_arb #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter logic       BIT_SEL     = 1'b1,
    parameter int         TWR_CYC     = 250_000,
    parameter int         TIMEOUT_CYC = 1_000_000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        r0_req,
    input  logic        r0_rh_wl,
    input  logic [15:0] r0_dev_addr,
    input  logic [7:0]  r0_wdata,
    output logic        r0_done,
    output logic        r0_err,
    input  logic        r1_req,
    input  logic        r1_rh_wl,
    input  logic [15:0] r1_dev_addr,
    input  logic [7:0]  r1_wdata,
    output logic        r1_done,
    output logic        r1_err,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        drv_en,
    output logic [6:0]  drv_slave_addr,
    output logic        drv_bit_sel,
    output logic        drv_rh_wl,
    output logic [15:0] drv_dev_addr,
    output logic [7:0]  drv_wdata,
    input  logic        drv_done,
    input  logic [7:0]  drv_rdata
);

    localparam int CNT_MAX = (TIMEOUT_CYC > TWR_CYC) ? TIMEOUT_CYC : TWR_CYC;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] C_TO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] C_TWR_LAST = CW'(TWR_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_WRWAIT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_sync_q1;
    logic            r_sync_q2;
    logic [CW-1:0]   r_cnt;
    logic            r_last_grant;
    logic            r_gnt_id;
    logic            r_err_flag;
    logic            r_drv_en;
    logic            r_drv_rh_wl;
    logic [15:0]     r_drv_dev_addr;
    logic [7:0]      r_drv_wdata;
    logic [7:0]      r_rd_data;

    logic            w_done_rise;
    logic            w_any_req;
    logic            w_pick;
    logic            w_to_hit;
    logic            w_twr_hit;

    assign w_done_rise = r_sync_q1 & ~r_sync_q2;
    assign w_any_req   = r0_req | r1_req;
    // On a tie the requester that did not win last time is served.
    assign w_pick      = (r0_req & r1_req) ? ~r_last_grant : r1_req;
    assign w_to_hit    = (r_cnt == C_TO_LAST);
    assign w_twr_hit   = (r_cnt == C_TWR_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next = S_ISSUE;
            S_ISSUE:  w_next = S_WAIT;
            S_WAIT: begin
                if (w_done_rise)   w_next = r_drv_rh_wl ? S_DONE : S_WRWAIT;
                else if (w_to_hit) w_next = S_DONE;
            end
            S_WRWAIT: if (w_twr_hit) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state        <= S_IDLE;
            r_sync_q1      <= 1'b0;
            r_sync_q2      <= 1'b0;
            r_cnt          <= '0;
            r_last_grant   <= 1'b1;
            r_gnt_id       <= 1'b0;
            r_err_flag     <= 1'b0;
            r_drv_en       <= 1'b0;
            r_drv_rh_wl    <= 1'b0;
            r_drv_dev_addr <= '0;
            r_drv_wdata    <= '0;
            r_rd_data      <= '0;
        end else begin
            r_state   <= w_next;
            r_sync_q1 <= drv_done;
            r_sync_q2 <= r_sync_q1;
            r_drv_en  <= (w_next == S_ISSUE) || (w_next == S_WAIT);
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt_id       <= w_pick;
                        r_drv_rh_wl    <= w_pick ? r1_rh_wl    : r0_rh_wl;
                        r_drv_dev_addr <= w_pick ? r1_dev_addr : r0_dev_addr;
                        r_drv_wdata    <= w_pick ? r1_wdata    : r0_wdata;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    // A completion seen on the terminal count still counts as success.
                    if (w_done_rise) begin
                        r_cnt <= '0;
                        if (r_drv_rh_wl) r_rd_data <= drv_rdata;
                    end else if (w_to_hit) begin
                        r_err_flag <= 1'b1;
                    end
                end
                S_WRWAIT: r_cnt <= r_cnt + CW'(1);
                S_DONE: begin
                    r_last_grant <= r_gnt_id;
                    r_err_flag   <= 1'b0;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign r0_done        = (r_state == S_DONE) & ~r_gnt_id;
    assign r1_done        = (r_state == S_DONE) &  r_gnt_id;
    assign r0_err         = r0_done & r_err_flag;
    assign r1_err         = r1_done & r_err_flag;
    assign busy           = (r_state != S_IDLE);
    assign rd_data        = r_rd_data;
    assign drv_en         = r_drv_en;
    assign drv_slave_addr = SLAVE_ADDR;
    assign drv_bit_sel    = BIT_SEL;
    assign drv_rh_wl      = r_drv_rh_wl;
    assign drv_dev_addr   = r_drv_dev_addr;
    assign drv_wdata      = r_drv_wdata;

endmodule

`default_nettype wire

// File: tb/tb_iic_arb.sv
// ============================================================================
// Module   : tb_iic_arb
// Brief    : Scoreboard bench for iic_arb with a behavioural IIC driver model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_iic_arb;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        r0_req, r0_rh_wl, r1_req, r1_rh_wl;
    logic [15:0] r0_dev_addr, r1_dev_addr;
    logic [7:0]  r0_wdata, r1_wdata;
    logic        r0_done, r0_err, r1_done, r1_err;
    logic [7:0]  rd_data;
    logic        busy, drv_en, drv_bit_sel, drv_rh_wl;
    logic [6:0]  drv_slave_addr;
    logic [15:0] drv_dev_addr;
    logic [7:0]  drv_wdata;
    logic        drv_done;
    logic [7:0]  drv_rdata;

    iic_arb #(.SLAVE_ADDR(7'h50), .BIT_SEL(1'b1), .TWR_CYC(100), .TIMEOUT_CYC(500)) u_dut (
        .Clk(Clk), .Rst(Rst),
        .r0_req(r0_req), .r0_rh_wl(r0_rh_wl), .r0_dev_addr(r0_dev_addr), .r0_wdata(r0_wdata),
        .r0_done(r0_done), .r0_err(r0_err),
        .r1_req(r1_req), .r1_rh_wl(r1_rh_wl), .r1_dev_addr(r1_dev_addr), .r1_wdata(r1_wdata),
        .r1_done(r1_done), .r1_err(r1_err),
        .rd_data(rd_data), .busy(busy), .drv_en(drv_en),
        .drv_slave_addr(drv_slave_addr), .drv_bit_sel(drv_bit_sel), .drv_rh_wl(drv_rh_wl),
        .drv_dev_addr(drv_dev_addr), .drv_wdata(drv_wdata),
        .drv_done(drv_done), .drv_rdata(drv_rdata)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        bit          id;
        bit          rh;
        logic [15:0] addr;
        logic [7:0]  wd;
        bit          err;
        logic [7:0]  rd;
        int          gap;    // cycles from drv_en fall to done
        int          enlen;  // cycles drv_en high, 0 = unchecked
        int          start;  // cycles from previous done to drv_en rise, 0 = unchecked
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   drv_delay = 0;
    logic [7:0] drv_resp = 8'h00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit id, input bit rh, input logic [15:0] a, input logic [7:0] w,
                        input bit err, input logic [7:0] rd, input int gap, input int enlen,
                        input int start);
        exp_t e;
        e.id = id; e.rh = rh; e.addr = a; e.wd = w; e.err = err; e.rd = rd;
        e.gap = gap; e.enlen = enlen; e.start = start;
        q_exp.push_back(e);
    endtask

    task automatic run_req(input bit id, input bit rh, input logic [15:0] a, input logic [7:0] w);
        bit got = 1'b0;
        if (id) begin r1_rh_wl = rh; r1_dev_addr = a; r1_wdata = w; r1_req = 1'b1; end
        else    begin r0_rh_wl = rh; r0_dev_addr = a; r0_wdata = w; r0_req = 1'b1; end
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge Clk); #1;
            got = id ? r1_done : r0_done;
        end
        if (id) r1_req = 1'b0; else r0_req = 1'b0;
        chk(id ? "r1_done_seen" : "r0_done_seen", got, 1'b1);
    endtask

    // Driver model: completes each command drv_delay cycles after drv_en rises.
    initial begin : drv_model
        int d;
        drv_done  = 1'b0;
        drv_rdata = 8'h00;
        forever begin
            wait (drv_en === 1'b1);
            d = drv_delay;
            if (d >= 0) begin
                repeat (d) @(posedge Clk);
                #3 drv_rdata = drv_resp;
                drv_done = 1'b1;
                repeat (3) @(posedge Clk);
                #3 drv_done = 1'b0;
            end
            wait (drv_en === 1'b0);
        end
    end

    initial begin : monitor
        int   cyc = 0, rise_cyc = 0, fall_cyc = 0, last_done = 0, start_gap = 0;
        bit   prev_en = 0, inflight = 0, busy_ok = 1;
        exp_t e;
        forever begin
            @(negedge Clk);
            cyc++;
            if (Rst) begin
                prev_en  = 0;
                inflight = 0;
            end else begin
                if (drv_en && !prev_en) begin
                    start_gap = cyc - last_done;
                    rise_cyc  = cyc;
                    inflight  = 1;
                    busy_ok   = 1;
                    if (q_exp.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_grant: drv_en rose with nothing expected at %0t", $time);
                    end else begin
                        e = q_exp[0];
                        chk("drv_cmd", {drv_rh_wl, drv_dev_addr, drv_wdata}, {e.rh, e.addr, e.wd});
                    end
                end
                if (!drv_en && prev_en) fall_cyc = cyc;
                if (inflight && !busy) busy_ok = 0;
                if (r0_done || r1_done) begin
                    if (q_exp.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_done: r0_done=%0b r1_done=%0b at %0t",
                                 r0_done, r1_done, $time);
                    end else begin
                        e = q_exp.pop_front();
                        chk("done_id", r1_done, e.id);
                        chk("both_done", r0_done & r1_done, 1'b0);
                        chk("err", e.id ? r1_err : r0_err, e.err);
                        chk("other_err", e.id ? r0_err : r1_err, 1'b0);
                        chk("rd_data", rd_data, e.rd);
                        chk("en_low_at_done", drv_en, 1'b0);
                        chk("done_gap", cyc - fall_cyc, e.gap);
                        chk("busy_held", busy_ok, 1'b1);
                        if (e.enlen != 0) chk("en_len", fall_cyc - rise_cyc, e.enlen);
                        if (e.start != 0) chk("grant_start", start_gap, e.start);
                    end
                    inflight  = 0;
                    last_done = cyc;
                end
                prev_en = drv_en;
            end
        end
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        Rst = 1'b1;
        r0_req = 0; r0_rh_wl = 0; r0_dev_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_rh_wl = 0; r1_dev_addr = '0; r1_wdata = '0;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("reset_outputs", {r0_done, r0_err, r1_done, r1_err, rd_data, busy, drv_en,
                              drv_rh_wl, drv_dev_addr, drv_wdata}, '0);
        chk("slave_addr", drv_slave_addr, 7'h50);
        chk("bit_sel", drv_bit_sel, 1'b1);

        // Single read, completion 3 us after drv_en.
        drv_delay = 150; drv_resp = 8'hA5;
        push(0, 1, 16'h0010, 8'h00, 0, 8'hA5, 0, 0, 0);
        run_req(0, 1, 16'h0010, 8'h00);

        // Write: done 100 cycles after drv_en drops; rd_data keeps last read.
        drv_delay = 4;
        push(1, 0, 16'h0100, 8'h3C, 0, 8'hA5, 100, 0, 0);
        run_req(1, 0, 16'h0100, 8'h3C);

        // Both pending: grants alternate starting with r0.
        push(0, 0, 16'h1000, 8'h11, 0, 8'hA5, 100, 0, 0);
        push(1, 0, 16'h2000, 8'h22, 0, 8'hA5, 100, 0, 0);
        push(0, 0, 16'h1001, 8'h33, 0, 8'hA5, 100, 0, 0);
        push(1, 0, 16'h2001, 8'h44, 0, 8'hA5, 100, 0, 0);
        fork
            begin run_req(0, 0, 16'h1000, 8'h11); run_req(0, 0, 16'h1001, 8'h33); end
            begin run_req(1, 0, 16'h2000, 8'h22); run_req(1, 0, 16'h2001, 8'h44); end
        join

        // Timeout: ISSUE plus 500 WAIT cycles, then error done, no write wait.
        drv_delay = -1;
        push(0, 1, 16'h0055, 8'h00, 1, 8'hA5, 0, 501, 0);
        run_req(0, 1, 16'h0055, 8'h00);

        // r0 raised during r1's write wait is issued two cycles after r1_done.
        drv_delay = 4; drv_resp = 8'h5A;
        push(1, 0, 16'h0200, 8'h99, 0, 8'hA5, 100, 0, 0);
        push(0, 1, 16'h0300, 8'h00, 0, 8'h5A, 0, 0, 2);
        fork
            run_req(1, 0, 16'h0200, 8'h99);
            begin
                for (int i = 0; i < 1000 && !drv_en; i++) @(posedge Clk);
                for (int i = 0; i < 1000 && drv_en; i++) @(posedge Clk);
                repeat (10) @(posedge Clk);
                #1 run_req(0, 1, 16'h0300, 8'h00);
            end
        join

        // Reset while waiting on the driver aborts silently.
        drv_delay = -1;
        push(0, 1, 16'h0400, 8'h00, 0, 8'h00, 0, 0, 0);
        r0_rh_wl = 1; r0_dev_addr = 16'h0400; r0_wdata = 8'h00; r0_req = 1'b1;
        for (int i = 0; i < 100 && !drv_en; i++) @(posedge Clk);
        chk("abort_en_high", drv_en, 1'b1);
        repeat (10) @(posedge Clk);
        #1 Rst = 1'b1; r0_req = 1'b0;
        q_exp.delete();
        @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("abort_state", {drv_en, busy, r0_done, r1_done, rd_data}, '0);
        repeat (20) @(posedge Clk);

        drv_delay = 5; drv_resp = 8'hC3;
        #1 push(0, 1, 16'h0010, 8'h00, 0, 8'hC3, 0, 0, 0);
        run_req(0, 1, 16'h0010, 8'h00);

        repeat (5) @(posedge Clk);
        chk("queue_empty", q_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
